// File: rtl/minc_p.sv
// minc_p: single-issue register/stack microcore. One instruction per valid fetch,
// 16 registers, internal data RAM holding both data and the call/return stack.
module minc_p #(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 8,
  parameter int unsigned NREG = 16
) (
  input  logic            CLK,
  input  logic            nRESET,
  output logic [AW-1:0]   imem_addr,
  input  logic [DW+6:0]   imem_data,
  input  logic            imem_valid,
  output logic [AW-1:0]   pc_out,
  output logic [AW-1:0]   sp_out,
  output logic [DW-1:0]   top_out,
  output logic            halted
);
  localparam int unsigned IW        = DW + 7;
  localparam int unsigned RAM_DEPTH = 1 << AW;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_STM  = 3'b010;
  localparam logic [2:0] OP_LDM  = 3'b011;
  localparam logic [2:0] OP_JCC  = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;

  localparam logic [3:0] SUB_MOV  = 4'b0000;
  localparam logic [3:0] SUB_ADD  = 4'b0001;
  localparam logic [3:0] SUB_SUB  = 4'b0010;
  localparam logic [3:0] SUB_MUL  = 4'b0011;
  localparam logic [3:0] SUB_PUSH = 4'b1000;
  localparam logic [3:0] SUB_LDS  = 4'b1001;
  localparam logic [3:0] SUB_POP  = 4'b1010;
  localparam logic [3:0] SUB_STS  = 4'b1011;
  localparam logic [3:0] SUB_RET  = 4'b1100;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc, r_sp, w_pc_nxt, w_sp_nxt;
  logic            r_zero, r_carry, w_zero_nxt, w_carry_nxt;
  logic [DW-1:0]   r_regs [NREG];
  logic [DW-1:0]   r_ram  [RAM_DEPTH];

  logic            w_reg_we, w_ram_we;
  logic [3:0]      w_reg_wa;
  logic [DW-1:0]   w_reg_wd, w_ram_wd;
  logic [AW-1:0]   w_ram_wa;

  logic [2:0]      w_op;
  logic [3:0]      w_sub, w_rs_idx, w_rd_idx;
  logic [DW-1:0]   w_imm, w_rs, w_rd, w_mul, w_top;
  logic [DW:0]     w_sum, w_diff;
  logic [AW-1:0]   w_maddr, w_sp_dec, w_sp_inc, w_pc_inc, w_imm_tgt;
  logic            w_taken;

  // Field decode; rd sits in the low nibble for odd opcodes (mvi/ldm)
  assign w_op     = imem_data[IW-1 -: 3];
  assign w_sub    = imem_data[IW-4 -: 4];
  assign w_imm    = imem_data[DW+3:4];
  assign w_rs_idx = imem_data[3:0];
  assign w_rd_idx = w_op[0] ? imem_data[3:0] : imem_data[7:4];

  assign w_rs      = r_regs[w_rs_idx];
  assign w_rd      = r_regs[w_rd_idx];
  assign w_sum     = {1'b0, w_rd} + {1'b0, w_rs};
  assign w_diff    = {1'b0, w_rd} - {1'b0, w_rs};
  assign w_mul     = w_rd * w_rs;
  assign w_top     = r_ram[r_sp];
  assign w_maddr   = AW'(r_regs[15] + w_imm);
  assign w_sp_dec  = r_sp - AW'(1);
  assign w_sp_inc  = r_sp + AW'(1);
  assign w_pc_inc  = r_pc + AW'(1);
  assign w_imm_tgt = AW'(w_imm);

  always_comb begin
    case (imem_data[1:0])
      2'b00:   w_taken = r_zero;
      2'b01:   w_taken = r_carry;
      2'b10:   w_taken = !r_zero;
      default: w_taken = !r_carry;
    endcase
  end

  // Next-state, datapath writes and flag updates for the fetched instruction
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_zero_nxt  = r_zero;
    w_carry_nxt = r_carry;
    w_reg_we    = 1'b0;
    w_reg_wa    = w_rd_idx;
    w_reg_wd    = '0;
    w_ram_we    = 1'b0;
    w_ram_wa    = w_sp_dec;
    w_ram_wd    = w_rs;
    if (r_state == ST_RUN && imem_valid) begin
      w_pc_nxt = w_pc_inc;
      case (w_op)
        OP_ALU: begin
          case (w_sub)
            SUB_MOV: begin
              w_reg_we   = 1'b1;
              w_reg_wd   = w_rs;
              w_zero_nxt = (w_rs == '0);
            end
            SUB_ADD: begin
              w_reg_we    = 1'b1;
              w_reg_wd    = w_sum[DW-1:0];
              w_zero_nxt  = (w_sum[DW-1:0] == '0);
              w_carry_nxt = w_sum[DW];
            end
            SUB_SUB: begin
              w_reg_we    = 1'b1;
              w_reg_wd    = w_diff[DW-1:0];
              w_zero_nxt  = (w_diff[DW-1:0] == '0);
              w_carry_nxt = w_diff[DW];
            end
            SUB_MUL: begin
              w_reg_we    = 1'b1;
              w_reg_wd    = w_mul;
              w_zero_nxt  = (w_mul == '0);
              w_carry_nxt = 1'b0;
            end
            SUB_PUSH: begin
              w_ram_we = 1'b1;
              w_sp_nxt = w_sp_dec;
            end
            SUB_LDS: w_sp_nxt = AW'(w_rs);
            SUB_POP: begin
              w_reg_we = 1'b1;
              w_reg_wd = w_top;
              w_sp_nxt = w_sp_inc;
            end
            SUB_STS: begin
              w_reg_we = 1'b1;
              w_reg_wd = DW'(r_sp);
            end
            SUB_RET: begin
              w_pc_nxt = AW'(w_top) + AW'(1);
              w_sp_nxt = w_sp_inc;
            end
            default: ;
          endcase
        end
        OP_MVI: begin
          w_reg_we = 1'b1;
          w_reg_wd = w_imm;
        end
        OP_STM: begin
          w_ram_we = 1'b1;
          w_ram_wa = w_maddr;
        end
        OP_LDM: begin
          w_reg_we = 1'b1;
          w_reg_wd = r_ram[w_maddr];
        end
        OP_JCC:  if (w_taken) w_pc_nxt = w_imm_tgt;
        OP_CALL: begin
          w_ram_we = 1'b1;
          w_ram_wd = DW'(r_pc);
          w_sp_nxt = w_sp_dec;
          w_pc_nxt = w_imm_tgt;
        end
        OP_JMP:  w_pc_nxt = w_imm_tgt;
        default: begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= ST_RUN;
      r_pc    <= '0;
      r_sp    <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sp    <= w_sp_nxt;
      r_zero  <= w_zero_nxt;
      r_carry <= w_carry_nxt;
      if (w_reg_we) r_regs[w_reg_wa] <= w_reg_wd;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge CLK) begin
    if (w_ram_we) r_ram[w_ram_wa] <= w_ram_wd;
  end

  assign imem_addr = r_pc;
  assign pc_out    = r_pc;
  assign sp_out    = r_sp;
  assign top_out   = w_top;
  assign halted    = (r_state == ST_HALT);

endmodule
